// File: rtl/axil_sram_slave.sv
// ---------------------------------------------------------------------------
// axil_sram_slave
//
// AXI4-Lite responder with on-chip 32-bit word memory, used to back
// instruction and data fetch. The read channel (AR/R) and write channel
// (AW/W/B) are served by two independent state machines. A programmable read
// latency stretches the time between the AR handshake and rvalid so that an
// initiator's wait logic is exercised.
//
// Parameters
//   BASE_ADDR   byte address of word 0
//   DEPTH_LOG2  log2 of the memory depth in 32-bit words
//   READ_LAT    cycles from the AR handshake to rvalid (1..15)
//   INIT_FILE   name of a memory image
//
// Optional feature macro
//   RESP_ERR_EN  when defined, addresses outside the memory window answer
//                with SLVERR (reads return zero, writes are dropped). When
//                undefined, addresses wrap modulo the depth and every
//                response is OKAY.
//
// Ports
//   clk                      clock, all state on the rising edge
//   rst                      asynchronous reset, active low
//   arvalid/arready/araddr   read address channel (araddr[1:0] ignored)
//   rvalid/rready/rdata/rresp  read data channel
//   awvalid/awready/awaddr   write address channel (awaddr[1:0] ignored)
//   wvalid/wready/wdata/wstrb  write data channel, wstrb[i] enables byte i
//   bvalid/bready/bresp      write response channel
// ---------------------------------------------------------------------------
module axil_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          READ_LAT   = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  // read data channel
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  // write address channel
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  // write data channel
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  // write response channel
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  // Word storage. It has no reset: contents survive a reset, and a write that
  // committed before reset stays visible afterwards.
  logic [31:0] mem [0:DEPTH-1];

  // Byte address to word index: offset from the base, dropped byte lane,
  // truncated to the memory depth (which also gives the wrap-around).
  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
    word_index = DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
  endfunction

  // Address error flags for the incoming AR and AW addresses. Subtracting the
  // base as an unsigned value turns addresses below the base into huge
  // offsets, so a single upper-bits test covers both ends of the window.
  logic ar_addr_err;
  logic aw_addr_err;

`ifdef RESP_ERR_EN
  assign ar_addr_err = ((araddr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign aw_addr_err = ((awaddr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
  assign ar_addr_err = 1'b0;
  assign aw_addr_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_t              r_state;
  r_state_t              r_state_next;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] ar_idx;
  logic                  ar_err;

  // Read state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Read next-state and handshake outputs. rvalid comes purely from the state,
  // so it never depends on rready.
  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt == 4'd0) begin
          r_state_next = R_RESP;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          r_state_next = R_IDLE;
        end
      end
      default: begin
        r_state_next = R_IDLE;
      end
    endcase
  end

  // Read datapath: capture the request, count down the latency, then sample
  // the memory once. The sample happens on the edge that leaves R_WAIT, so a
  // write committing on that same edge is not seen (old data returned).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 4'd0;
      ar_idx <= '0;
      ar_err <= 1'b0;
      rdata  <= 32'd0;
      rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            ar_idx <= word_index(araddr);
            ar_err <= ar_addr_err;
            cnt    <= 4'(READ_LAT - 1);
          end
        end
        R_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata <= ar_err ? 32'd0 : mem[ar_idx];
            rresp <= ar_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_t              w_state;
  w_state_t              w_state_next;
  logic                  aw_done;
  logic                  w_done;
  logic [DEPTH_LOG2-1:0] aw_idx;
  logic                  aw_err;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_err;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;

  // Write state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_next;
    end
  end

  // Write next-state, ready/valid outputs and commit decision. AW and W are
  // taken independently; the write commits on the edge where the second of
  // the two arrives (or both together). Values being handed over this cycle
  // bypass the capture registers so the commit does not wait an extra cycle.
  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    commit       = 1'b0;
    wr_idx       = aw_idx;
    wr_err       = aw_err;
    wr_data      = w_data;
    wr_strb      = w_strb;
    case (w_state)
      W_IDLE: begin
        awready = !aw_done;
        wready  = !w_done;
        aw_fire = awvalid && !aw_done;
        w_fire  = wvalid && !w_done;
        if (aw_fire) begin
          wr_idx = word_index(awaddr);
          wr_err = aw_addr_err;
        end
        if (w_fire) begin
          wr_data = wdata;
          wr_strb = wstrb;
        end
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          commit       = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: begin
        w_state_next = W_IDLE;
      end
    endcase
  end

  // Write capture registers and response code. The captured flags keep
  // awready/wready low for the half already taken and are only released when
  // the response is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_idx  <= '0;
      aw_err  <= 1'b0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_done <= 1'b1;
        aw_idx  <= word_index(awaddr);
        aw_err  <= aw_addr_err;
      end
      if (w_fire) begin
        w_done <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) begin
        bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (bvalid && bready) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Byte-masked memory write. Gated by rst so that nothing is written while
  // reset is held, even if an initiator keeps AW and W asserted.
  always_ff @(posedge clk) begin
    if (rst && commit && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_sram_slave
//
// Directed testbench for axil_sram_slave. Two instances share the write
// channel: dut uses a read latency of 1, dut4 a read latency of 4. Each has
// its own read channel so the latencies can be driven and observed
// separately.
// ---------------------------------------------------------------------------
module tb_axil_sram_slave;

  logic        clk;
  logic        rst;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic        arvalid4;
  logic        arready4;
  logic [31:0] araddr4;
  logic        rvalid4;
  logic        rready4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  logic        awready4;
  logic        wready4;
  logic        bvalid4;
  logic [1:0]  bresp4;

  int          n_cmp;
  int          n_err;

  axil_sram_slave #(.READ_LAT(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp)
  );

  axil_sram_slave #(.READ_LAT(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .arvalid (arvalid4),
    .arready (arready4),
    .araddr  (araddr4),
    .rvalid  (rvalid4),
    .rready  (rready4),
    .rdata   (rdata4),
    .rresp   (rresp4),
    .awvalid (awvalid),
    .awready (awready4),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready4),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid4),
    .bready  (bready),
    .bresp   (bresp4)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a handshake loop is broken in an unexpected way.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge; inputs change and outputs are
  // sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts, asserts, reports on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full write with AW and W offered together; waits (bounded) for each
  // handshake and for the response, then accepts it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] exp_bresp,
                               input string tag);
    bit a_hs;
    bit w_hs;
    int k;
    awvalid = 1'b1;
    awaddr  = addr;
    wvalid  = 1'b1;
    wdata   = data;
    wstrb   = strb;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      tick();
      if (a_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    checkOutput({tag, "_aw_w_accepted"}, {30'd0, awvalid, wvalid}, 32'd0);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    k = 0;
    while (!bvalid && k < 20) begin
      tick();
      k++;
    end
    checkOutput({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    checkOutput({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_bresp});
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Full read on dut (sel=0) or dut4 (sel=1); checks latency measured from the
  // AR handshake edge to rvalid, then data and response.
  task automatic doRead(input bit sel, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp, input int exp_lat, input string tag);
    bit hs;
    int lat;
    hs = 1'b0;
    if (sel) begin
      arvalid4 = 1'b1;
      araddr4  = addr;
    end else begin
      arvalid = 1'b1;
      araddr  = addr;
    end
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = sel ? arready4 : arready;
      tick();
    end
    arvalid  = 1'b0;
    arvalid4 = 1'b0;
    checkOutput({tag, "_ar_hs"}, {31'd0, hs}, 32'd1);
    lat = 0;
    while (!(sel ? rvalid4 : rvalid) && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_rdata"}, sel ? rdata4 : rdata, exp_data);
    checkOutput({tag, "_rresp"}, {30'd0, sel ? rresp4 : rresp}, {30'd0, exp_resp});
    if (sel) rready4 = 1'b1; else rready = 1'b1;
    tick();
    rready  = 1'b0;
    rready4 = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    arvalid  = 1'b0;
    araddr   = 32'd0;
    rready   = 1'b0;
    arvalid4 = 1'b0;
    araddr4  = 32'd0;
    rready4  = 1'b0;
    awvalid  = 1'b0;
    awaddr   = 32'd0;
    wvalid   = 1'b0;
    wdata    = 32'd0;
    wstrb    = 4'd0;
    bready   = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_arready", {31'd0, arready}, 32'd1);
    checkOutput("rst_awready", {31'd0, awready}, 32'd1);
    checkOutput("rst_wready",  {31'd0, wready},  32'd1);
    checkOutput("rst_rvalid",  {31'd0, rvalid},  32'd0);
    checkOutput("rst_bvalid",  {31'd0, bvalid},  32'd0);
    checkOutput("rst_rdata",   rdata,            32'd0);
    checkOutput("rst_rresp",   {30'd0, rresp},   32'd0);
    checkOutput("rst_bresp",   {30'd0, bresp},   32'd0);
    rst = 1'b1;
    tick();

    // T1: simple write then 1-cycle-latency read
    $display("[TB] T1 write/read");
    applyStimulus(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, "t1_wr");
    checkOutput("t1_awready_back", {31'd0, awready}, 32'd1);
    doRead(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1, "t1_rd");
    doRead(1'b0, 32'h8000_0013, 32'hDEAD_BEEF, 2'b00, 1, "t1_rd_lane");
    checkOutput("t1_arready_back", {31'd0, arready}, 32'd1);

    // T2: 4-cycle latency with back-pressure on R
    $display("[TB] T2 latency 4 with rready held low");
    applyStimulus(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 2'b00, "t2_wr");
    arvalid4 = 1'b1;
    araddr4  = 32'h8000_0040;
    checkOutput("t2_arready_idle", {31'd0, arready4}, 32'd1);
    tick();
    arvalid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_rvalid_early", {31'd0, rvalid4}, 32'd0);
      checkOutput("t2_arready_wait", {31'd0, arready4}, 32'd0);
      tick();
    end
    checkOutput("t2_rvalid_rise", {31'd0, rvalid4}, 32'd1);
    checkOutput("t2_rdata", rdata4, 32'h0BAD_F00D);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2_rvalid_hold", {31'd0, rvalid4}, 32'd1);
      checkOutput("t2_rdata_hold", rdata4, 32'h0BAD_F00D);
      checkOutput("t2_arready_hold", {31'd0, arready4}, 32'd0);
    end
    rready4 = 1'b1;
    tick();
    rready4 = 1'b0;
    checkOutput("t2_rvalid_done", {31'd0, rvalid4}, 32'd0);
    checkOutput("t2_arready_done", {31'd0, arready4}, 32'd1);

    // T3: W ahead of AW, partial strobe, held response
    $display("[TB] T3 W before AW");
    applyStimulus(32'h8000_0030, 32'h1122_3344, 4'hF, 2'b00, "t3_pre");
    wvalid = 1'b1;
    wdata  = 32'h0000_AB00;
    wstrb  = 4'b0010;
    checkOutput("t3_wready_idle", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t3_wready_low", {31'd0, wready}, 32'd0);
      checkOutput("t3_awready_high", {31'd0, awready}, 32'd1);
      checkOutput("t3_bvalid_none", {31'd0, bvalid}, 32'd0);
      if (k < 2) tick();
    end
    awvalid = 1'b1;
    awaddr  = 32'h8000_0030;
    tick();
    awvalid = 1'b0;
    checkOutput("t3_bvalid", {31'd0, bvalid}, 32'd1);
    checkOutput("t3_bresp", {30'd0, bresp}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("t3_bvalid_hold", {31'd0, bvalid}, 32'd1);
      checkOutput("t3_awready_resp", {31'd0, awready}, 32'd0);
      checkOutput("t3_wready_resp", {31'd0, wready}, 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("t3_bvalid_done", {31'd0, bvalid}, 32'd0);
    checkOutput("t3_awready_back", {31'd0, awready}, 32'd1);
    checkOutput("t3_wready_back", {31'd0, wready}, 32'd1);
    doRead(1'b0, 32'h8000_0030, 32'h1122_AB44, 2'b00, 1, "t3_rd");
    applyStimulus(32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 2'b00, "t3_nostrb");
    doRead(1'b0, 32'h8000_0030, 32'h1122_AB44, 2'b00, 1, "t3_rd_nostrb");

    // T4: address window handling
    $display("[TB] T4 address range");
    applyStimulus(32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 2'b00, "t4_w0");
    applyStimulus(32'h8000_3FFC, 32'h0000_7777, 4'hF, 2'b00, "t4_wlast");
    doRead(1'b0, 32'h8000_3FFC, 32'h0000_7777, 2'b00, 1, "t4_rlast");
`ifdef RESP_ERR_EN
    doRead(1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 1, "t4_rd_below");
    doRead(1'b0, 32'h8000_4000, 32'h0000_0000, 2'b10, 1, "t4_rd_above");
    applyStimulus(32'h9000_0000, 32'h1234_5678, 4'hF, 2'b10, "t4_wr_err");
    doRead(1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 2'b00, 1, "t4_rd_unchanged");
`else
    doRead(1'b0, 32'h7FFF_FFFC, 32'h0000_7777, 2'b00, 1, "t4_rd_wrap_low");
    applyStimulus(32'h9000_0000, 32'h1234_5678, 4'hF, 2'b00, "t4_wr_wrap");
    doRead(1'b0, 32'h8000_0000, 32'h1234_5678, 2'b00, 1, "t4_rd_wrapped");
`endif

    // T5: read sample and write commit on the same edge
    $display("[TB] T5 read/write collision");
    applyStimulus(32'h8000_0020, 32'h0000_0000, 4'hF, 2'b00, "t5_pre");
    arvalid = 1'b1;
    araddr  = 32'h8000_0020;
    tick();
    arvalid = 1'b0;
    awvalid = 1'b1;
    awaddr  = 32'h8000_0020;
    wvalid  = 1'b1;
    wdata   = 32'h0000_0005;
    wstrb   = 4'hF;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("t5_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("t5_rdata_old", rdata, 32'h0000_0000);
    checkOutput("t5_bvalid", {31'd0, bvalid}, 32'd1);
    rready = 1'b1;
    bready = 1'b1;
    tick();
    rready = 1'b0;
    bready = 1'b0;
    doRead(1'b0, 32'h8000_0020, 32'h0000_0005, 2'b00, 1, "t5_rd_new");

    // T6: reset in the middle of a read and of a half-captured write
    $display("[TB] T6 reset mid-transaction");
    arvalid  = 1'b1;
    araddr   = 32'h8000_0010;
    arvalid4 = 1'b1;
    araddr4  = 32'h8000_0010;
    wvalid   = 1'b1;
    wdata    = 32'hEEEE_EEEE;
    wstrb    = 4'hF;
    tick();
    arvalid  = 1'b0;
    arvalid4 = 1'b0;
    wvalid   = 1'b0;
    checkOutput("t6_in_wait", {31'd0, arready}, 32'd0);
    checkOutput("t6_w_taken", {31'd0, wready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t6_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("t6_arready", {31'd0, arready}, 32'd1);
    checkOutput("t6_rvalid4", {31'd0, rvalid4}, 32'd0);
    checkOutput("t6_arready4", {31'd0, arready4}, 32'd1);
    checkOutput("t6_wready", {31'd0, wready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(32'h8000_0050, 32'h1357_9BDF, 4'hF, 2'b00, "t6_wr");
    doRead(1'b0, 32'h8000_0050, 32'h1357_9BDF, 2'b00, 1, "t6_rd");
    doRead(1'b1, 32'h8000_0050, 32'h1357_9BDF, 2'b00, 4, "t6_rd4");
    doRead(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1, "t6_rd_persist");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
